// File: rtl/pem_common_param_pkg.sv
// Shared PEM constants and types: AXI4 response/burst encodings and the
// write-responder FSM state and debug-info bundle.
package pem_common_param_pkg;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI4_BURST_INCR  = 2'b01;

  localparam int unsigned PEM_WR_PTR_W  = 32;
  localparam int unsigned PEM_WR_BEAT_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } pem_wr_rsp_state_e;

  typedef struct packed {
    pem_wr_rsp_state_e         state;
    logic                      err;
    logic [PEM_WR_PTR_W-1:0]   ptr;
    logic [PEM_WR_BEAT_W-1:0]  beat;
  } pem_wr_rsp_info_t;

endpackage

// File: rtl/pem_axi4_wr_rsp_ram.sv
// Word RAM for the write responder: one byte-enabled write port and one
// registered read port that returns the old word on a same-cycle collision.
module pem_axi4_wr_rsp_ram #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_add,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W/8-1:0]        wr_be,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_add,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned ADD_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_in_range;

  generate
    if (DEPTH == (1 << ADD_W)) begin : g_full
      assign rd_in_range = 1'b1;
    end else begin : g_part
      assign rd_in_range = (rd_add < ADD_W'(DEPTH));
    end
  endgenerate

  // Byte-masked write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (wr_be[i]) mem[wr_add][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // Registered side read; out-of-range words read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_in_range ? mem[rd_add] : '0;
    end
  end

endmodule

// File: rtl/pem_axi4_wr_rsp.sv
// AXI4 write-channel responder for one PEM pseudo-channel: accepts one
// AW/W burst at a time into a word RAM, returns in-order B responses and
// exposes a 1-cycle side read port plus burst/error counters.
module pem_axi4_wr_rsp
  import pem_common_param_pkg::*;
#(
  parameter int unsigned           AXI4_DATA_W = 512,
  parameter int unsigned           AXI4_ADD_W  = 32,
  parameter int unsigned           AXI4_ID_W   = 1,
  parameter int unsigned           MEM_DEPTH   = 64,
  parameter logic [AXI4_ADD_W-1:0] BASE_ADD    = '0
) (
  input  logic                         clk,
  input  logic                         s_rst,
  input  logic [AXI4_ID_W-1:0]         s_axi4_awid,
  input  logic [AXI4_ADD_W-1:0]        s_axi4_awaddr,
  input  logic [7:0]                   s_axi4_awlen,
  input  logic [2:0]                   s_axi4_awsize,
  input  logic [1:0]                   s_axi4_awburst,
  input  logic                         s_axi4_awvalid,
  output logic                         s_axi4_awready,
  input  logic [AXI4_DATA_W-1:0]       s_axi4_wdata,
  input  logic [AXI4_DATA_W/8-1:0]     s_axi4_wstrb,
  input  logic                         s_axi4_wlast,
  input  logic                         s_axi4_wvalid,
  output logic                         s_axi4_wready,
  output logic [AXI4_ID_W-1:0]         s_axi4_bid,
  output logic [1:0]                   s_axi4_bresp,
  output logic                         s_axi4_bvalid,
  input  logic                         s_axi4_bready,
  input  logic                         mem_rd_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_rd_add,
  output logic [AXI4_DATA_W-1:0]       mem_rd_data,
  output logic [31:0]                  burst_cnt,
  output logic [31:0]                  err_cnt
);

  localparam int unsigned AXI4_DATA_BYTES = AXI4_DATA_W / 8;
  localparam int unsigned BYTE_LG         = $clog2(AXI4_DATA_BYTES);
  localparam int unsigned RAM_AW          = $clog2(MEM_DEPTH);

  pem_wr_rsp_info_t       info_q, info_d;
  logic [AXI4_ID_W-1:0]   id_q, id_d;
  logic [7:0]             len_q, len_d;

  logic                      aw_hs, w_hs, b_hs;
  logic [AXI4_ADD_W:0]       aw_off;
  logic [PEM_WR_PTR_W-1:0]   aw_ptr;
  logic [PEM_WR_PTR_W:0]     aw_end;
  logic                      aw_err;
  logic [PEM_WR_BEAT_W-1:0]  beat_len;
  logic                      ram_we;

  // BASE_ADD is word aligned, so alignment of the offset equals alignment of awaddr.
  assign aw_off   = {1'b0, s_axi4_awaddr} - {1'b0, BASE_ADD};
  assign aw_ptr   = PEM_WR_PTR_W'(aw_off[AXI4_ADD_W-1:BYTE_LG]);
  assign aw_end   = {1'b0, aw_ptr} + (PEM_WR_PTR_W+1)'(s_axi4_awlen);
  assign aw_err   = (s_axi4_awburst != AXI4_BURST_INCR)
                 || (s_axi4_awsize != 3'(BYTE_LG))
                 || (aw_off[BYTE_LG-1:0] != '0)
                 || aw_off[AXI4_ADD_W]
                 || (aw_end >= (PEM_WR_PTR_W+1)'(MEM_DEPTH));
  assign beat_len = PEM_WR_BEAT_W'(len_q);

  assign s_axi4_awready = !s_rst && (info_q.state == IDLE);
  assign s_axi4_wready  = !s_rst && (info_q.state == DATA);
  assign s_axi4_bvalid  = !s_rst && (info_q.state == RESP);
  assign s_axi4_bid     = s_axi4_bvalid ? id_q : '0;
  assign s_axi4_bresp   = (s_axi4_bvalid && info_q.err) ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;

  assign aw_hs = s_axi4_awvalid && s_axi4_awready;
  assign w_hs  = s_axi4_wvalid && s_axi4_wready;
  assign b_hs  = s_axi4_bvalid && s_axi4_bready;

  // FSM state and burst context register.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      info_q <= '{state: IDLE, err: 1'b0, ptr: '0, beat: '0};
      id_q   <= '0;
      len_q  <= '0;
    end else begin
      info_q <= info_d;
      id_q   <= id_d;
      len_q  <= len_d;
    end
  end

  // Next-state, error tracking and RAM write enable.
  always_comb begin
    info_d = info_q;
    id_d   = id_q;
    len_d  = len_q;
    ram_we = 1'b0;
    case (info_q.state)
      IDLE: begin
        if (aw_hs) begin
          id_d         = s_axi4_awid;
          len_d        = s_axi4_awlen;
          info_d.ptr   = aw_ptr;
          info_d.beat  = '0;
          info_d.err   = aw_err;
          info_d.state = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          // err is the value before this beat, so the beat that exposes an
          // early/missing wlast is itself still written.
          ram_we      = !info_q.err && (info_q.beat <= beat_len);
          info_d.ptr  = info_q.ptr + PEM_WR_PTR_W'(1);
          info_d.beat = info_q.beat + PEM_WR_BEAT_W'(1);
          if (s_axi4_wlast) begin
            info_d.state = RESP;
            if (info_q.beat < beat_len) info_d.err = 1'b1;
          end else if (info_q.beat == beat_len) begin
            info_d.err = 1'b1;
          end
        end
      end
      RESP: begin
        if (b_hs) info_d.state = IDLE;
      end
      default: info_d.state = IDLE;
    endcase
  end

  // Completed-response counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      burst_cnt <= '0;
      err_cnt   <= '0;
    end else if (b_hs) begin
      burst_cnt <= burst_cnt + 32'd1;
      if (info_q.err) err_cnt <= err_cnt + 32'd1;
    end
  end

  pem_axi4_wr_rsp_ram #(
    .DATA_W (AXI4_DATA_W),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (s_rst),
    .wr_en   (ram_we),
    .wr_add  (info_q.ptr[RAM_AW-1:0]),
    .wr_data (s_axi4_wdata),
    .wr_be   (s_axi4_wstrb),
    .rd_en   (mem_rd_en),
    .rd_add  (mem_rd_add),
    .rd_data (mem_rd_data)
  );

endmodule

// File: tb/tb_pem_axi4_wr_rsp.sv
// Bench for pem_axi4_wr_rsp: table of bursts with expected responses,
// B scoreboard queue, shadow RAM model checked through the side read port,
// plus hand-written reset-mid-burst sequence.
module tb_pem_axi4_wr_rsp;

  localparam int DW    = 512;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            s_rst = 1'b1;
  logic [0:0]      awid = '0;
  logic [31:0]     awaddr = '0;
  logic [7:0]      awlen = '0;
  logic [2:0]      awsize = '0;
  logic [1:0]      awburst = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [NB-1:0]   wstrb = '0;
  logic            wlast = 1'b0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [0:0]      bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic            rd_en = 1'b0;
  logic [5:0]      rd_add = '0;
  logic [DW-1:0]   rd_data;
  logic [31:0]     burst_cnt, err_cnt;

  always #5 clk = ~clk;

  pem_axi4_wr_rsp #(
    .AXI4_DATA_W (DW),
    .AXI4_ADD_W  (32),
    .AXI4_ID_W   (1),
    .MEM_DEPTH   (DEPTH),
    .BASE_ADD    (32'h0)
  ) dut (
    .clk            (clk),
    .s_rst          (s_rst),
    .s_axi4_awid    (awid),
    .s_axi4_awaddr  (awaddr),
    .s_axi4_awlen   (awlen),
    .s_axi4_awsize  (awsize),
    .s_axi4_awburst (awburst),
    .s_axi4_awvalid (awvalid),
    .s_axi4_awready (awready),
    .s_axi4_wdata   (wdata),
    .s_axi4_wstrb   (wstrb),
    .s_axi4_wlast   (wlast),
    .s_axi4_wvalid  (wvalid),
    .s_axi4_wready  (wready),
    .s_axi4_bid     (bid),
    .s_axi4_bresp   (bresp),
    .s_axi4_bvalid  (bvalid),
    .s_axi4_bready  (bready),
    .mem_rd_en      (rd_en),
    .mem_rd_add     (rd_add),
    .mem_rd_data    (rd_data),
    .burst_cnt      (burst_cnt),
    .err_cnt        (err_cnt)
  );

  typedef struct {
    logic [1:0] resp;
    logic       id;
  } exp_t;

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          last_at;
    int          strb_beat;
    int          hold;
    logic [7:0]  dbyte;
    bit          coll;
    bit          aw_bad;
    logic [1:0]  resp;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] wd [16];
  logic [NB-1:0] ws [16];
  exp_t          sbq [$];
  int unsigned   exp_bursts = 0;
  int unsigned   exp_errs = 0;
  vec_t          vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input int last_at,
                              input int strb_beat, input int hold, input logic [7:0] dbyte,
                              input bit coll, input bit aw_bad, input logic [1:0] resp);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.last_at = last_at; v.strb_beat = strb_beat; v.hold = hold; v.dbyte = dbyte;
    v.coll = coll; v.aw_bad = aw_bad; v.resp = resp;
    return v;
  endfunction

  task automatic rd_check(input int w, input string nm);
    rd_en  = 1'b1;
    rd_add = 6'(w);
    tick();
    rd_en  = 1'b0;
    if (known[w]) chk(nm, rd_data, model[w]);
  endtask

  task automatic do_burst(input vec_t v);
    int            n;
    int            p;
    exp_t          e;
    logic [DW-1:0] oldv;
    p = int'(v.addr[11:6]);
    for (int b = 0; b < 16; b++) begin
      if (v.dbyte != 8'h00) wd[b] = {NB{v.dbyte}};
      else for (int k = 0; k < DW / 32; k++) wd[b][k*32 +: 32] = $urandom();
      ws[b] = (b == v.strb_beat) ? NB'(64'h0F) : '1;
    end
    awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    if (!awready) chk("aw_timeout", 0, 1);
    tick();
    awvalid = 1'b0;
    e.resp = v.resp; e.id = v.id;
    sbq.push_back(e);
    oldv = '0;
    for (int b = 0; b <= v.last_at; b++) begin
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == v.last_at); wvalid = 1'b1;
      if (v.coll && b == 0) begin
        rd_en = 1'b1; rd_add = 6'(p); oldv = model[p];
      end
      n = 0;
      while (!wready && n < 20) begin tick(); n++; end
      if (!wready) chk("w_timeout", 0, 1);
      tick();
      if (v.coll && b == 0) chk("coll_old", rd_data, oldv);
      if (!v.aw_bad && b <= int'(v.len) && b <= v.last_at && p + b < DEPTH)
        for (int k = 0; k < NB; k++)
          if (ws[b][k]) model[p+b][k*8 +: 8] = wd[b][k*8 +: 8];
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (v.coll) begin
      tick();
      chk("coll_new", rd_data, model[p]);
      rd_en = 1'b0;
    end
    bready = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      chk("hold_bvalid", bvalid, 1);
      chk("hold_bid", bid, sbq[0].id);
      chk("hold_bresp", bresp, sbq[0].resp);
      tick();
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (!bvalid) chk("b_timeout", 0, 1);
    else begin
      e = sbq.pop_front();
      chk("bid", bid, e.id);
      chk("bresp", bresp, e.resp);
      tick();
      exp_bursts++;
      if (e.resp == 2'b10) exp_errs++;
    end
    bready = 1'b0;
    chk("burst_cnt", burst_cnt, exp_bursts);
    chk("err_cnt", err_cnt, exp_errs);
    chk("awready_after_b", awready, 1);
    for (int b = 0; b <= v.last_at; b++)
      if (p + b < DEPTH) rd_check(p + b, "ram_word");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin model[i] = '0; known[i] = 1'b0; end

    vecs[0]  = mk(0, 32'd0,        15, 6, 2'b01, 15, -1, 0, 8'h00, 0, 0, 2'b00);
    vecs[1]  = mk(1, 32'd1024,     15, 6, 2'b01, 15, -1, 0, 8'h00, 0, 0, 2'b00);
    vecs[2]  = mk(0, 32'd2048,     15, 6, 2'b01, 15, -1, 0, 8'h00, 0, 0, 2'b00);
    vecs[3]  = mk(1, 32'd3072,     15, 6, 2'b01, 15, -1, 0, 8'h00, 0, 0, 2'b00);
    vecs[4]  = mk(0, 32'd0,         0, 6, 2'b01,  0, -1, 0, 8'hA5, 0, 0, 2'b00);
    vecs[5]  = mk(1, 32'd512,       3, 6, 2'b01,  3,  2, 5, 8'h00, 0, 0, 2'b00);
    vecs[6]  = mk(0, 32'd3968,      3, 6, 2'b01,  3, -1, 0, 8'h00, 0, 1, 2'b10);
    vecs[7]  = mk(1, 32'd1920,      3, 6, 2'b01,  1, -1, 2, 8'h00, 0, 0, 2'b10);
    vecs[8]  = mk(0, 32'd2560,      1, 6, 2'b01,  3, -1, 0, 8'h00, 0, 0, 2'b10);
    vecs[9]  = mk(1, 32'd768,       0, 6, 2'b00,  0, -1, 0, 8'h00, 0, 1, 2'b10);
    vecs[10] = mk(0, 32'd832,       0, 5, 2'b01,  0, -1, 0, 8'h00, 0, 1, 2'b10);
    vecs[11] = mk(1, 32'd900,       0, 6, 2'b01,  0, -1, 0, 8'h00, 0, 1, 2'b10);
    vecs[12] = mk(0, 32'd3840,      3, 6, 2'b01,  3, -1, 0, 8'h00, 0, 0, 2'b00);
    vecs[13] = mk(1, 32'd320,       0, 6, 2'b01,  0, -1, 0, 8'h11, 1, 0, 2'b00);

    // Reset values.
    repeat (3) tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_burst_cnt", burst_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    s_rst = 1'b0;
    #1;

    // The four fill bursts make every RAM word known before the checks run.
    for (int i = 0; i < 14; i++) begin
      do_burst(vecs[i]);
      if (i == 3) for (int w = 0; w < DEPTH; w++) known[w] = 1'b1;
    end

    // Reset after two beats of a 4-beat burst at word 20.
    awid = 1'b1; awaddr = 32'd1280; awlen = 8'd3; awsize = 3'd6; awburst = 2'b01;
    awvalid = 1'b1;
    chk("mid_awready", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < DW / 32; k++) wd[b][k*32 +: 32] = $urandom();
      wdata = wd[b]; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
      chk("mid_wready", wready, 1);
      tick();
      model[20+b] = wd[b];
    end
    wvalid = 1'b0;
    s_rst = 1'b1;
    tick();
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_awready", awready, 0);
    chk("mid_rst_burst_cnt", burst_cnt, 0);
    s_rst = 1'b0;
    #1;
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready", wready, 0);
    chk("post_rst_bvalid", bvalid, 0);
    exp_bursts = 0;
    exp_errs = 0;
    for (int w = 20; w < 24; w++) rd_check(w, "post_rst_ram");

    do_burst(mk(0, 32'd1280, 0, 6, 2'b01, 0, -1, 0, 8'h00, 0, 0, 2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
